// File: rtl/m92_sound_pkg.sv
// ============================================================================
// Module : m92_sound_pkg
// Brief  : Shared types and constants for the M92 sound command/reply mailbox.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package m92_sound_pkg;

  // V35-side addresses of the command latch and the reply/status port.
  localparam logic [19:0] SND_LATCH_CMD_ADDR = 20'ha8044;
  localparam logic [19:0] SND_LATCH_RPL_ADDR = 20'ha8046;

  typedef logic [7:0] snd_byte_t;

  // Value presented to the V35 while no command is held.
  localparam snd_byte_t SND_RESET_CMD = 8'hff;

endpackage : m92_sound_pkg

`default_nettype wire

// File: rtl/strobe_rise.sv
// ============================================================================
// Module : strobe_rise
// Brief  : Registered rising-edge detector for a level CPU strobe. A strobe
//          held high for many clocks yields a single one-clock pulse, one
//          clock after the edge is sampled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module strobe_rise (
  input  logic clk_sys,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic r_hist;
  logic r_rise;

  // History keeps tracking the live strobe while reset is held, so a level
  // that is already high when reset releases is not mistaken for a new edge;
  // a strobe that is low through reset leaves the history at 0.
  always_ff @(posedge clk_sys) begin
    r_hist <= in;
  end

  // Edge pulse register; forced low during reset so no event leaks out.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rise <= 1'b0;
    end else begin
      r_rise <= in & ~r_hist;
    end
  end

  assign rise = r_rise;

endmodule : strobe_rise

`default_nettype wire

// File: rtl/sound_cmd_latch.sv
// ============================================================================
// Module : sound_cmd_latch
// Brief  : Main-CPU <-> V35 command/reply mailbox. Command bytes from the main
//          CPU interrupt the V35 until acknowledged; reply bytes from the V35
//          interrupt the main CPU until read.
//          Build option SOUND_CMD_FIFO_EN turns the single command latch into
//          a FIFO_DEPTH-entry command FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import m92_sound_pkg::*;

module sound_cmd_latch #(
  parameter int        FIFO_DEPTH = 4,
  parameter snd_byte_t RESET_CMD  = SND_RESET_CMD
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       main_cmd_wr,
  input  logic [7:0] main_cmd_data,
  input  logic       main_rpl_rd,
  output logic [7:0] main_rpl_data,
  output logic       main_rpl_irq,
  input  logic       snd_cmd_rd,
  output logic [7:0] snd_cmd_data,
  input  logic       snd_cmd_ack,
  input  logic       snd_rpl_wr,
  input  logic [7:0] snd_rpl_data,
  output logic       snd_cmd_irq,
  output logic       cmd_overflow
);

  // Port addresses are decoded upstream; kept here only for trace alignment.
  localparam logic [19:0] c_unused_addr_xor = SND_LATCH_CMD_ADDR ^ SND_LATCH_RPL_ADDR;

  // The V35 command read is non-destructive and has no effect on state.
  logic w_unused_cmd_rd;
  assign w_unused_cmd_rd = snd_cmd_rd;

  // --------------------------------------------------------------------------
  // Strobe edge detection (events are one clock behind the sampled edge)
  // --------------------------------------------------------------------------
  logic w_cmd_wr_ev;
  logic w_rpl_rd_ev;
  logic w_cmd_ack_ev;
  logic w_rpl_wr_ev;

  strobe_rise u_rise_cmd_wr (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in      (main_cmd_wr),
    .rise    (w_cmd_wr_ev)
  );

  strobe_rise u_rise_rpl_rd (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in      (main_rpl_rd),
    .rise    (w_rpl_rd_ev)
  );

  strobe_rise u_rise_cmd_ack (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in      (snd_cmd_ack),
    .rise    (w_cmd_ack_ev)
  );

  strobe_rise u_rise_rpl_wr (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in      (snd_rpl_wr),
    .rise    (w_rpl_wr_ev)
  );

  // Data buses are captured on the same edge the strobe rise is sampled, so
  // they line up with the delayed event pulses.
  snd_byte_t r_cmd_smp;
  snd_byte_t r_rpl_smp;

  // Sample both data buses every clock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cmd_smp <= 8'h00;
      r_rpl_smp <= 8'h00;
    end else begin
      r_cmd_smp <= main_cmd_data;
      r_rpl_smp <= snd_rpl_data;
    end
  end

  // --------------------------------------------------------------------------
  // Reply path: V35 status byte towards the main CPU
  // --------------------------------------------------------------------------
  snd_byte_t r_rpl_byte;
  logic      r_rpl_irq;

  // A reply write always wins over a simultaneous main-CPU read.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rpl_byte <= 8'h00;
      r_rpl_irq  <= 1'b0;
    end else if (w_rpl_wr_ev) begin
      r_rpl_byte <= r_rpl_smp;
      r_rpl_irq  <= 1'b1;
    end else if (w_rpl_rd_ev) begin
      r_rpl_irq  <= 1'b0;
    end
  end

  assign main_rpl_data = r_rpl_byte;
  assign main_rpl_irq  = r_rpl_irq;

  // --------------------------------------------------------------------------
  // Command path
  // --------------------------------------------------------------------------
  logic r_overflow;

`ifdef SOUND_CMD_FIFO_EN

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

  snd_byte_t          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_cnt);
  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when the head is being popped in the same cycle.
  assign w_pop   = w_cmd_ack_ev & ~w_empty;
  assign w_push  = w_cmd_wr_ev & (~w_full | w_pop);
  assign w_drop  = w_cmd_wr_ev & w_full & ~w_pop;

  // Storage write at the tail; no reset needed because count gates reads.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_cmd_smp;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky loss flag, set when a byte is dropped against a full FIFO.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Head byte is driven straight from state registers.
  assign snd_cmd_data = w_empty ? RESET_CMD : r_mem[r_rd_ptr];
  assign snd_cmd_irq  = ~w_empty;

`else

  localparam int c_unused_depth = FIFO_DEPTH;

  snd_byte_t r_cmd_byte;
  logic      r_cmd_pend;

  // Single latch: a write always wins over a same-cycle ack; the byte keeps
  // its last value after the ack so the V35 can re-read it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cmd_byte <= RESET_CMD;
      r_cmd_pend <= 1'b0;
    end else if (w_cmd_wr_ev) begin
      r_cmd_byte <= r_cmd_smp;
      r_cmd_pend <= 1'b1;
    end else if (w_cmd_ack_ev) begin
      r_cmd_pend <= 1'b0;
    end
  end

  // Sticky loss flag: a pending byte overwritten before it was acknowledged.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_cmd_wr_ev & r_cmd_pend & ~w_cmd_ack_ev) begin
      r_overflow <= 1'b1;
    end
  end

  assign snd_cmd_data = r_cmd_byte;
  assign snd_cmd_irq  = r_cmd_pend;

`endif

  assign cmd_overflow = r_overflow;

endmodule : sound_cmd_latch

`default_nettype wire
